// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forward-select encodings,
// mult/div sequencer states and the default register index width.
package hazard_ctrl_pkg;

    localparam int unsigned REG_BITS = 5;

    // E-stage operand mux selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    // M-stage match wins over W-stage match
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_MEM;
        end else if (hit_w) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mult/div sequencer: counts the E-stage busy cycles of a MULT/DIV and
// pulses md_done in the cycle the unit latches HI/LO.
module hazard_ctrl_md_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_BITS   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start_e,
    input  logic md_is_div_e,
    output logic md_busy,
    output logic md_done
);

    // Counter holds remaining BUSY cycles minus one, so N busy cycles precede DONE
    localparam logic [CNT_BITS-1:0] MulLoad = CNT_BITS'(MUL_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] DivLoad = CNT_BITS'(DIV_CYCLES - 1);

    md_state_t           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; starts are only accepted in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_e) begin
                    cnt_d   = md_is_div_e ? DivLoad : MulLoad;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end else begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_busy = (state_q != MD_IDLE);
    assign md_done = (state_q == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: E/D-stage forwarding selects,
// load-use / branch / HI-LO stall and flush, and the mult/div sequencer.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_BITS   = hazard_ctrl_pkg::REG_BITS,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_BITS   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] rs_d,
    input  logic [REG_BITS-1:0] rt_d,
    input  logic [REG_BITS-1:0] rs_e,
    input  logic [REG_BITS-1:0] rt_e,
    input  logic [REG_BITS-1:0] write_reg_e,
    input  logic [REG_BITS-1:0] write_reg_m,
    input  logic [REG_BITS-1:0] write_reg_w,
    input  logic                reg_write_e,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    input  logic                mem_to_reg_e,
    input  logic                mem_to_reg_m,
    input  logic                branch_d,
    input  logic                md_start_e,
    input  logic                md_is_div_e,
    input  logic                hilo_use_d,
    output logic [1:0]          forward_a_e,
    output logic [1:0]          forward_b_e,
    output logic                forward_a_d,
    output logic                forward_b_d,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_e,
    output logic                md_busy,
    output logic                md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         fwd_cnt,
    output logic [31:0]         md_cnt
`endif
);

    logic wr_m_live, wr_w_live, wr_e_live, ld_m_live;
    logic lw_stall, br_stall, md_stall, stall;

    // Register 0 is hard-wired, so a write to it never creates a dependency
    assign wr_m_live = reg_write_m && (write_reg_m != '0);
    assign wr_w_live = reg_write_w && (write_reg_w != '0);
    assign wr_e_live = reg_write_e && (write_reg_e != '0);
    assign ld_m_live = mem_to_reg_m && (write_reg_m != '0);

    // Forwarding selects and stall conditions
    always_comb begin
        forward_a_e = fwd_sel(wr_m_live && (write_reg_m == rs_e),
                              wr_w_live && (write_reg_w == rs_e));
        forward_b_e = fwd_sel(wr_m_live && (write_reg_m == rt_e),
                              wr_w_live && (write_reg_w == rt_e));
        forward_a_d = wr_m_live && (write_reg_m == rs_d);
        forward_b_d = wr_m_live && (write_reg_m == rt_d);

        lw_stall = mem_to_reg_e && (write_reg_e != '0) &&
                   ((write_reg_e == rs_d) || (write_reg_e == rt_d));
        br_stall = branch_d &&
                   ((wr_e_live && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                    (ld_m_live && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
        md_stall = hilo_use_d && md_busy;
        stall    = lw_stall || br_stall || md_stall;
    end

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    hazard_ctrl_md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_BITS   (CNT_BITS)
    ) u_md_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

`ifdef HAZARD_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
            md_cnt    <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (((forward_a_e != FWD_REG) || (forward_b_e != FWD_REG)) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
            if (md_done && (md_cnt != '1)) begin
                md_cnt <= md_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
    logic [4:0] write_reg_e = '0, write_reg_m = '0, write_reg_w = '0;
    logic       reg_write_e = 0, reg_write_m = 0, reg_write_w = 0;
    logic       mem_to_reg_e = 0, mem_to_reg_m = 0, branch_d = 0;
    logic       md_start_e = 0, md_is_div_e = 0, hilo_use_d = 0;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_a_d, forward_b_d, stall_f, stall_d, flush_e, md_busy, md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt, md_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: cycles left until the sequencer is idle again (0 = idle, 1 = done cycle)
    int md_left = 0;
    int m_stall_cnt = 0, m_fwd_cnt = 0, m_md_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .branch_d     (branch_d),
        .md_start_e   (md_start_e),
        .md_is_div_e  (md_is_div_e),
        .hilo_use_d   (hilo_use_d),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .forward_a_d  (forward_a_d),
        .forward_b_d  (forward_b_d),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .md_busy      (md_busy),
        .md_done      (md_done)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt),
        .md_cnt       (md_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Which pipeline-register writer, if any, supplies source register src
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (reg_write_m && write_reg_m != 0 && write_reg_m == src) return 2'd2;
        if (reg_write_w && write_reg_w != 0 && write_reg_w == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic model_stall();
        logic uses_e_ld, uses_e_wr, uses_m_ld;
        uses_e_ld = mem_to_reg_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d);
        uses_e_wr = reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d);
        uses_m_ld = mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d);
        return uses_e_ld || (branch_d && (uses_e_wr || uses_m_ld)) || (hilo_use_d && md_left != 0);
    endfunction

    // Model update at each clock edge (inputs change 1 time unit after the edge)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_left     = 0;
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
            m_md_cnt    = 0;
        end else begin
            if (model_stall()) m_stall_cnt++;
            if (model_fwd(rs_e) != 0 || model_fwd(rt_e) != 0) m_fwd_cnt++;
            if (md_left == 1) m_md_cnt++;
            if (md_left > 0) md_left--;
            else if (md_start_e) md_left = (md_is_div_e ? DIV_N : MUL_N) + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic s;
        s = model_stall();
        chk("forward_a_e", 32'(forward_a_e), 32'(model_fwd(rs_e)));
        chk("forward_b_e", 32'(forward_b_e), 32'(model_fwd(rt_e)));
        chk("forward_a_d", 32'(forward_a_d), 32'(model_fwd(rs_d) == 2'd2));
        chk("forward_b_d", 32'(forward_b_d), 32'(model_fwd(rt_d) == 2'd2));
        chk("stall_f", 32'(stall_f), 32'(s));
        chk("stall_d", 32'(stall_d), 32'(s));
        chk("flush_e", 32'(flush_e), 32'(s));
        chk("md_busy", 32'(md_busy), 32'(md_left != 0));
        chk("md_done", 32'(md_done), 32'(md_left == 1));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
        chk("fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
        chk("md_cnt", md_cnt, 32'(m_md_cnt));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
        {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
        {branch_d, md_start_e, md_is_div_e, hilo_use_d} = '0;
    endtask

    initial begin
        int nb, nd, ns, done_at;
`ifdef HAZARD_STATS_EN
        logic [31:0] md_cnt0;
`endif
        // Reset state
        @(negedge clk);
        chk("rst md_busy", 32'(md_busy), 0);
        chk("rst md_done", 32'(md_done), 0);
        chk("rst stall_d", 32'(stall_d), 0);
        chk("rst forward_a_e", 32'(forward_a_e), 0);
        #2 rst_n = 1'b1;

        // Forwarding priority and register 0
        step();
        reg_write_m = 1; write_reg_m = 8; reg_write_w = 1; write_reg_w = 8; rs_e = 8;
        @(negedge clk); chk("fwd M over W", 32'(forward_a_e), 32'h2);
        step(); reg_write_m = 0;
        @(negedge clk); chk("fwd W", 32'(forward_a_e), 32'h1);
        step(); rs_e = 0; write_reg_m = 0; write_reg_w = 0; reg_write_m = 1;
        @(negedge clk); chk("fwd r0", 32'(forward_a_e), 32'h0);

        // Load-use stall, then the load sits in M with no branch
        step(); clear_inputs(); mem_to_reg_e = 1; write_reg_e = 9; rt_d = 9;
        @(negedge clk);
        chk("lw stall_f", 32'(stall_f), 1);
        chk("lw flush_e", 32'(flush_e), 1);
        step(); mem_to_reg_e = 0; write_reg_e = 0; mem_to_reg_m = 1; reg_write_m = 1;
        write_reg_m = 9;
        @(negedge clk); chk("lw in M no stall", 32'(stall_d), 0);

        // Branch compare forwarding and branch-on-load stall
        step(); clear_inputs(); branch_d = 1; rs_d = 5; reg_write_m = 1; write_reg_m = 5;
        @(negedge clk);
        chk("br forward_a_d", 32'(forward_a_d), 1);
        chk("br alu no stall", 32'(stall_d), 0);
        step(); mem_to_reg_m = 1;
        @(negedge clk); chk("br load stall", 32'(stall_d), 1);

        // MULT: 5 busy cycles, done in cycle 5, HI/LO consumer stalled throughout
        step(); clear_inputs(); hilo_use_d = 1; md_start_e = 1;
        step(); md_start_e = 0;
        nb = 0; ns = 0; done_at = 0; nd = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (md_busy) nb++;
            if (stall_d) ns++;
            if (md_done) begin done_at = c; nd++; end
        end
        chk("mul busy cycles", 32'(nb), 5);
        chk("mul done cycle", 32'(done_at), 5);
        chk("mul done pulses", 32'(nd), 1);
        chk("mul stall cycles", 32'(ns), 5);

        // DIV abandoned by reset mid-operation, then a fresh start is accepted
        step(); clear_inputs(); md_start_e = 1; md_is_div_e = 1;
        step(); md_start_e = 0; md_is_div_e = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst mid md_busy", 32'(md_busy), 0);
        chk("rst mid md_done", 32'(md_done), 0);
        @(negedge clk); rst_n = 1;
        step(); md_start_e = 1;
        step(); md_start_e = 0;
        @(negedge clk); chk("restart busy", 32'(md_busy), 1);
        repeat (8) @(posedge clk);
        #1;

        // Start during BUSY ignored: done timing and count unchanged
`ifdef HAZARD_STATS_EN
        md_cnt0 = md_cnt;
`endif
        md_start_e = 1;
        step(); md_start_e = 0;
        nb = 0; done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (md_busy) nb++;
            if (md_done) done_at = c;
            #1;
            if (c == 2) begin md_start_e = 1; md_is_div_e = 1; end
            if (c == 3) begin md_start_e = 0; md_is_div_e = 0; end
        end
        chk("ignore busy cycles", 32'(nb), 5);
        chk("ignore done cycle", 32'(done_at), 5);
`ifdef HAZARD_STATS_EN
        chk("md_cnt delta", md_cnt - md_cnt0, 1);
`endif

        // Randomized traffic; compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            rs_d = 5'($urandom_range(0, 3));
            rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));
            rt_e = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3));
            write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom);
            reg_write_m = 1'($urandom);
            reg_write_w = 1'($urandom);
            mem_to_reg_e = 1'($urandom);
            mem_to_reg_m = 1'($urandom);
            branch_d = 1'($urandom);
            md_start_e = ($urandom_range(0, 5) == 0);
            md_is_div_e = ($urandom_range(0, 3) == 0);
            hilo_use_d = 1'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        step(); rst_n = 1; clear_inputs();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
